pkt_wr_arbiter: RTL and testbench
=================================

PKT_WR_ARBITER -- requirements
Module: pkt_wr_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (fixed at 4; rr pointer and gnt_id are 2 bits).
REQ-002 Parameter: W, 10, packet word width, matching the shared packet FIFO.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req_valid  input  NREQ  per-requester word valid.
REQ-006 Port: req_last  input  NREQ  per-requester end-of-packet flag, qualified by req_valid.
REQ-007 Port: req_data  input  NREQ*W  packed words; requester i occupies bits [W*i+W-1 : W*i].
REQ-008 Port: req_ready  output  NREQ  per-requester word accepted this cycle.
REQ-009 Port: fifo_full  input  1  shared FIFO full flag (FIFO capacity 15 words).
REQ-010 Port: fifo_we  output  1  write enable to shared FIFO.
REQ-011 Port: fifo_pkti  output  W  write data to shared FIFO.
REQ-012 Port: gnt_id  output  2  index of requester currently granted.
REQ-013 Port: busy  output  1  high while a multi-word packet holds the lock.

Function
REQ-014 Transfer on requester i SHALL occur in a cycle iff req_valid[i] and req_ready[i] are both high; at most one bit of req_ready SHALL be high per cycle.
REQ-015 The block SHALL implement two states, IDLE and LOCKED, plus a 2-bit round-robin pointer rr_ptr and a 2-bit owner register.
REQ-016 In IDLE with fifo_full low, the winner SHALL be the first requester with req_valid high, searching rr_ptr, rr_ptr+1, ... mod 4; req_ready[winner] SHALL be high in the same cycle (zero latency).
REQ-017 In IDLE with fifo_full high, or with no req_valid, req_ready SHALL be all zeros and state SHALL not change.
REQ-018 IDLE transfer with req_last high: stay IDLE, rr_ptr <= winner+1 mod 4.
REQ-019 IDLE transfer with req_last low: go to LOCKED, owner <= winner.
REQ-020 In LOCKED, only req_ready[owner] SHALL be asserted, equal to ~fifo_full; all other requesters SHALL be blocked regardless of their req_valid.
REQ-021 In LOCKED, if the owner drops req_valid, the block SHALL stay LOCKED with fifo_we low (no timeout).
REQ-022 LOCKED transfer with req_last high: go to IDLE, rr_ptr <= owner+1 mod 4; next arbitration is possible in the following cycle.
REQ-023 fifo_we SHALL equal the OR of (req_valid & req_ready); fifo_pkti SHALL carry the transferring requester's word when fifo_we is high, else zero.
REQ-024 The FIFO SHALL never be written while fifo_full is high.
REQ-025 gnt_id SHALL show the combinational winner in IDLE (rr_ptr when no request) and owner in LOCKED; busy SHALL be high iff state is LOCKED.
REQ-026 Arithmetic on rr_ptr and owner SHALL wrap modulo 4 (3+1 = 0).

Reset
REQ-027 On rst high at a clock edge: state <= IDLE, rr_ptr <= 0, owner <= 0, statistics counters <= 0; a packet in progress is abandoned without further writes.
REQ-028 While rst is high, req_ready, fifo_we, fifo_pkti and busy SHALL be 0 and gnt_id SHALL be 0.

Configuration
REQ-029 Macro PKT_WR_ARBITER_STATS_EN, when defined, SHALL add output port gnt_cnt (NREQ*8 bits, requester i at [8i+7:8i]), counting completed packets (transfer with req_last high) per requester, saturating at 255, reset to 0.
REQ-030 Without PKT_WR_ARBITER_STATS_EN, the gnt_cnt port and its counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 After reset, all four req_valid high with req_last high, fifo_full low, for 4 cycles -> grants in order 0,1,2,3; fifo_pkti equals each requester's word.
REQ-032 Requester 2 sends 3-word packet (last on word 3) while requester 0 is valid -> req_ready = 0100 for 3 cycles, busy high for cycles 2-3, then requester 0 granted; rr_ptr = 3.
REQ-033 fifo_full high mid-packet for 2 cycles -> fifo_we = 0 and req_ready = 0 for those cycles, packet resumes with the same owner, no word lost or duplicated.
REQ-034 rr_ptr = 3 with only requester 1 valid -> requester 1 granted; afterwards rr_ptr = 2.
REQ-035 rst asserted in LOCKED after word 2 of a 4-word packet -> next cycle IDLE, busy = 0, rr_ptr = 0, no further fifo_we until a new request.
REQ-036 With PKT_WR_ARBITER_STATS_EN, 300 single-word packets from requester 3 -> gnt_cnt[31:24] = 255, other fields 0.

Source files
------------

// File: rtl/pkt_wr_arbiter.sv
// Round-robin write arbiter: four requesters share one packet FIFO, and a multi-word packet keeps the grant until its last word.
// Defining PKT_WR_ARBITER_STATS_EN adds gnt_cnt, a saturating count of completed packets per requester.
module pkt_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              fifo_full,
  output logic              fifo_we,
  output logic [W-1:0]      fifo_pkti,
  output logic [1:0]        gnt_id,
  output logic              busy
`ifdef PKT_WR_ARBITER_STATS_EN
  ,
  output logic [NREQ*8-1:0] gnt_cnt
`endif
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e     state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] win_id;
  logic       win_found;
  logic [1:0] xfer_id;
  logic       xfer_last;

  // The search runs from the lowest priority up, so the highest-priority valid requester wins.
  // With no valid requester the result is ptr.
  function automatic logic [1:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
    logic [1:0] pick;
    pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (valid[ptr + 2'(k)]) pick = ptr + 2'(k);
    end
    return pick;
  endfunction

  always_comb begin
    // NOTE: every combinational output and next-state term gets a default first, so no path can infer a latch.
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    req_ready = '0;
    fifo_pkti = '0;
    busy      = 1'b0;
    gnt_id    = rr_ptr_q;
    xfer_id   = rr_ptr_q;
    win_found = |req_valid;
    win_id    = rr_pick(req_valid, rr_ptr_q);

    if (state_q == IDLE) begin
      xfer_id = win_id;
      gnt_id  = win_id;
      if (win_found && !fifo_full) req_ready[win_id] = 1'b1;
    end else begin
      xfer_id            = owner_q;
      gnt_id             = owner_q;
      busy               = 1'b1;
      req_ready[owner_q] = !fifo_full;
    end

    fifo_we   = |(req_valid & req_ready);
    xfer_last = req_last[xfer_id];

    if (fifo_we) begin
      fifo_pkti = req_data[int'(xfer_id)*W +: W];
      if (xfer_last) begin
        state_d  = IDLE;
        rr_ptr_d = xfer_id + 2'd1;
      end else if (state_q == IDLE) begin
        state_d = LOCKED;
        owner_d = xfer_id;
      end
    end

    // While reset is held, all outputs read as idle.
    if (rst) begin
      req_ready = '0;
      fifo_we   = 1'b0;
      fifo_pkti = '0;
      gnt_id    = '0;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment, so every flop samples the values from before the edge.
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

`ifdef PKT_WR_ARBITER_STATS_EN
  logic [7:0] cnt_q [NREQ];
  logic [7:0] cnt_d [NREQ];

  always_comb begin
    cnt_d = cnt_q;
    if (fifo_we && xfer_last && cnt_q[xfer_id] != 8'hFF)
      cnt_d[xfer_id] = cnt_q[xfer_id] + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign gnt_cnt[8*g +: 8] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_pkt_wr_arbiter.sv
// Self-checking bench for pkt_wr_arbiter: directed scenarios followed by random traffic.
// Every cycle is compared against a packet-level reference model.
module tb_pkt_wr_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_last, req_ready;
  logic [NREQ*W-1:0] req_data;
  logic              fifo_full, fifo_we, busy;
  logic [W-1:0]      fifo_pkti;
  logic [1:0]        gnt_id;
`ifdef PKT_WR_ARBITER_STATS_EN
  logic [NREQ*8-1:0] gnt_cnt;
`endif

  pkt_wr_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_we(fifo_we),
    .fifo_pkti(fifo_pkti), .gnt_id(gnt_id), .busy(busy)
`ifdef PKT_WR_ARBITER_STATS_EN
    , .gnt_cnt(gnt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, described as a packet owner and a priority origin.
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_cnt [4];

  // Values observed in the most recent cycle, used by the directed checks.
  logic [3:0]   obs_ready;
  logic         obs_we;
  logic [W-1:0] obs_pkti;
  logic [1:0]   obs_gnt;
  logic         obs_busy;
  logic [W-1:0] words [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // One clock cycle: drive the inputs, compare the outputs with the model, then advance the model.
  task automatic cycle(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f);
    int           win;
    logic [3:0]   e_ready;
    logic [1:0]   e_gnt;
    logic         e_we;
    logic [W-1:0] e_pkti;
    @(negedge clk);
    rst       = r;
    req_valid = v;
    req_last  = l;
    fifo_full = f;
    for (int i = 0; i < 4; i++) begin
      words[i] = W'($urandom);
      req_data[i*W +: W] = words[i];
    end
    #1;
    win     = -1;
    e_ready = '0;
    if (!m_locked) begin
      for (int k = 0; k < 4; k++)
        if (win < 0 && v[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
      e_gnt = (win < 0) ? 2'(m_ptr) : 2'(win);
      if (win >= 0 && !f) e_ready[win] = 1'b1;
    end else begin
      win   = m_owner;
      e_gnt = 2'(m_owner);
      if (!f) e_ready[m_owner] = 1'b1;
    end
    e_we   = |(e_ready & v);
    e_pkti = e_we ? words[win] : '0;
    if (r) begin
      e_ready = '0;
      e_we    = 1'b0;
      e_pkti  = '0;
      e_gnt   = '0;
    end
    obs_ready = req_ready;
    obs_we    = fifo_we;
    obs_pkti  = fifo_pkti;
    obs_gnt   = gnt_id;
    obs_busy  = busy;
    check("req_ready", 32'(req_ready), 32'(e_ready));
    check("fifo_we",   32'(fifo_we),   32'(e_we));
    check("fifo_pkti", 32'(fifo_pkti), 32'(e_pkti));
    check("gnt_id",    32'(gnt_id),    32'(e_gnt));
    check("busy",      32'(busy),      32'(m_locked && !r));
    check("we_while_full", 32'(fifo_we & fifo_full), 32'(0));
`ifdef PKT_WR_ARBITER_STATS_EN
    for (int i = 0; i < 4; i++) check("gnt_cnt", 32'(gnt_cnt[8*i +: 8]), 32'(m_cnt[i]));
`endif
    if (r) begin
      model_reset();
    end else if (e_we) begin
      if (l[win]) begin
        if (m_cnt[win] < 255) m_cnt[win]++;
        m_locked = 1'b0;
        m_ptr    = (win + 1) % 4;
      end else if (!m_locked) begin
        m_locked = 1'b1;
        m_owner  = win;
      end
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 4'b1111, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0000, 4'b0000, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    model_reset();

    // Reset state, with requests present while reset is held.
    do_reset();
    check("rst_ready", 32'(obs_ready), 32'(0));
    check("rst_gnt",   32'(obs_gnt),   32'(0));

    // All four requesters send single-word packets: the grants go 0,1,2,3.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'b1111, 4'b1111, 1'b0);
      check("rr_order", 32'(obs_gnt),   32'(i));
      check("rr_data",  32'(obs_pkti),  32'(words[i]));
    end

    // Requester 2 sends a 3-word packet while requester 0 waits.
    do_reset();
    cycle(1'b0, 4'b0010, 4'b0010, 1'b0);
    cycle(1'b0, 4'b0101, 4'b0001, 1'b0);
    check("lock_ready1", 32'(obs_ready), 32'(4'b0100));
    check("lock_busy1",  32'(obs_busy),  32'(0));
    cycle(1'b0, 4'b0101, 4'b0001, 1'b0);
    check("lock_ready2", 32'(obs_ready), 32'(4'b0100));
    check("lock_busy2",  32'(obs_busy),  32'(1));
    cycle(1'b0, 4'b0101, 4'b0101, 1'b0);
    check("lock_ready3", 32'(obs_ready), 32'(4'b0100));
    check("lock_busy3",  32'(obs_busy),  32'(1));
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0);
    check("rr_ptr_3", 32'(obs_gnt), 32'(3));
    cycle(1'b0, 4'b0001, 4'b0001, 1'b0);
    check("req0_after", 32'(obs_ready), 32'(4'b0001));

    // The FIFO goes full in the middle of a packet: the owner stalls and then resumes.
    begin
      int nw;
      nw = 0;
      cycle(1'b0, 4'b1000, 4'b0000, 1'b0); nw += int'(obs_we);
      cycle(1'b0, 4'b1001, 4'b0001, 1'b1);
      check("full_we1", 32'(obs_we), 32'(0));
      check("full_rdy1", 32'(obs_ready), 32'(0));
      cycle(1'b0, 4'b1001, 4'b0001, 1'b1);
      check("full_we2", 32'(obs_we), 32'(0));
      cycle(1'b0, 4'b1001, 4'b0001, 1'b0); nw += int'(obs_we);
      check("resume_owner", 32'(obs_gnt), 32'(3));
      cycle(1'b0, 4'b1001, 4'b1001, 1'b0); nw += int'(obs_we);
      check("pkt_words", 32'(nw), 32'(3));
      cycle(1'b0, 4'b0000, 4'b0000, 1'b0);
      check("ptr_wrap", 32'(obs_gnt), 32'(0));
    end

    // With rr_ptr at 3 and only requester 1 valid, requester 1 wins.
    cycle(1'b0, 4'b0100, 4'b0100, 1'b0);
    cycle(1'b0, 4'b0010, 4'b0010, 1'b0);
    check("ptr3_win", 32'(obs_ready), 32'(4'b0010));
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0);
    check("ptr_after1", 32'(obs_gnt), 32'(2));

    // Reset arrives after word 2 of a 4-word packet.
    cycle(1'b0, 4'b0010, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0010, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0010, 4'b0000, 1'b0);
    check("rst_lock_we", 32'(obs_we), 32'(0));
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 4'b0000, 4'b0000, 1'b0);
      check("post_rst_busy", 32'(obs_busy), 32'(0));
      check("post_rst_ptr",  32'(obs_gnt),  32'(0));
      check("post_rst_we",   32'(obs_we),   32'(0));
    end

    // Random traffic, including occasional reset pulses.
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] v, l;
      v = 4'($urandom);
      l = 4'($urandom) & 4'($urandom);
      cycle(($urandom_range(0, 99) == 0), v, l, ($urandom_range(0, 4) == 0));
    end

`ifdef PKT_WR_ARBITER_STATS_EN
    // Counter saturation: 300 single-word packets from requester 3.
    do_reset();
    for (int n = 0; n < 300; n++) cycle(1'b0, 4'b1000, 4'b1000, 1'b0);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0);
    check("cnt_sat3", 32'(gnt_cnt[31:24]), 32'(255));
    check("cnt_other", 32'(gnt_cnt[23:0]), 32'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
